// File: rtl/axi_bridge_ip_tx_pkg.sv
// Shared definitions for the AXI bridge TX serializer: width helpers,
// segment FSM encoding and the byte-keep mask function.
package axi_bridge_ip_tx_pkg;

    localparam int MAX_KEEP_W = 128;

    typedef enum logic [0:0] {
        SEG_IDLE = 1'b0,
        SEG_SEND = 1'b1
    } seg_fsm_e;

    function automatic int calc_max_segs(input int data_w, input int if_w);
        return (data_w + if_w - 1) / if_w;
    endfunction

    function automatic int calc_cnt_w(input int max_val);
        return $clog2(max_val + 1);
    endfunction

    // Lower nbytes bits set; callers truncate to their own lane count.
    function automatic logic [MAX_KEEP_W-1:0] mask_bytes(input logic [7:0] nbytes);
        logic [MAX_KEEP_W-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_KEEP_W; i++) begin
            m[i] = (i < int'(nbytes));
        end
        return m;
    endfunction

endpackage

// File: rtl/axi_bridge_ip_tx_ser_seg_outreg.sv
// Single-entry valid/ready output register; payload only moves on load.
module axi_bridge_ip_tx_ser_seg_outreg #(
    parameter int PAY_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             load_i,
    input  logic             ready_i,
    input  logic [PAY_W-1:0] payload_i,
    output logic             valid_o,
    output logic [PAY_W-1:0] payload_o
);

    logic             r_valid;
    logic [PAY_W-1:0] r_payload;

    // Valid flag: flush drops it, load sets it, acceptance without load clears it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else if (load_i) begin
            r_valid <= 1'b1;
        end else if (ready_i) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    // Payload capture; holds while the entry waits for ready.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_payload <= '0;
        end else if (load_i && !flush_i) begin
            r_payload <= payload_i;
        end else begin
            r_payload <= r_payload;
        end
    end

    assign valid_o   = r_valid;
    assign payload_o = r_payload;

endmodule

// File: rtl/axi_bridge_ip_tx_ser_segment_gen.sv
// TX serializer segment generator: slices a latched beat into IF_W segments,
// lowest bytes first, and releases the beat once its last segment is captured.
module axi_bridge_ip_tx_ser_segment_gen
    import axi_bridge_ip_tx_pkg::*;
#(
    parameter int DATA_W  = 256,
    parameter int IF_W    = 64,
    parameter int TUSER_W = 16,
    localparam int BYTES_PER_SEG = IF_W / 8,
    localparam int MAX_SEGS      = calc_max_segs(DATA_W, IF_W),
    localparam int SEG_CNT_W     = calc_cnt_w(MAX_SEGS),
    localparam int BYTE_CNT_W    = calc_cnt_w(DATA_W / 8),
    localparam int SEG_BYTES_W   = calc_cnt_w(BYTES_PER_SEG)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   enable_i,
    input  logic                   flush_i,
    input  logic                   beat_valid_i,
    input  logic [DATA_W-1:0]      beat_data_i,
    input  logic [TUSER_W-1:0]     beat_user_i,
    input  logic                   beat_last_i,
    input  logic [SEG_CNT_W-1:0]   beat_num_segs_i,
    input  logic [BYTE_CNT_W-1:0]  beat_last_seg_bytes_i,
    output logic                   beat_done_pulse_o,
    output logic                   seg_valid_o,
    input  logic                   seg_ready_i,
    output logic [IF_W-1:0]        seg_data_o,
    output logic [SEG_BYTES_W-1:0] seg_bytes_o,
    output logic [TUSER_W-1:0]     seg_user_o,
    output logic                   seg_sop_o,
    output logic                   seg_eop_o
);

    localparam int PAD_W = MAX_SEGS * IF_W;
    localparam int PAY_W = IF_W + SEG_BYTES_W + TUSER_W + 2;

    seg_fsm_e               r_state;
    logic [SEG_CNT_W-1:0]   r_seg_idx;
    logic                   r_sop_pending;

    logic                   w_seg_valid;
    logic                   w_state_ok;
    logic                   w_eligible;
    logic                   w_final;
    logic                   w_load;
    logic                   w_zero_rel;
    logic [BYTE_CNT_W-1:0]  w_bytes_full;
    logic [BYTES_PER_SEG-1:0] w_keep;
    logic [PAD_W-1:0]       w_padded;
    logic [IF_W-1:0]        w_slice;
    logic [IF_W-1:0]        w_seg_data;
    logic [PAY_W-1:0]       w_pay_d;
    logic [PAY_W-1:0]       w_pay_q;

    // Mid-beat continuation is only legal from SEND; a fresh beat starts at index 0.
    assign w_state_ok = (r_state == SEG_SEND) || (r_seg_idx == {SEG_CNT_W{1'b0}});
    assign w_eligible = enable_i && beat_valid_i && (beat_num_segs_i != {SEG_CNT_W{1'b0}}) && w_state_ok;
    assign w_final    = (r_seg_idx == (beat_num_segs_i - SEG_CNT_W'(1)));
    assign w_load     = !flush_i && w_eligible && (!w_seg_valid || seg_ready_i);
    assign w_zero_rel = !flush_i && beat_valid_i && (beat_num_segs_i == {SEG_CNT_W{1'b0}});

    // Done pulse is combinational on seg_ready_i through the load condition.
    assign beat_done_pulse_o = (w_load && w_final) || w_zero_rel;

    assign w_bytes_full = w_final ? beat_last_seg_bytes_i : BYTE_CNT_W'(BYTES_PER_SEG);
    assign w_keep       = BYTES_PER_SEG'(mask_bytes(8'(w_bytes_full)));

    // Zero-extend the beat so every segment slot is addressable.
    always_comb begin
        w_padded               = '0;
        w_padded[DATA_W-1:0]   = beat_data_i;
    end

    // Segment select as an AND-OR mux over the slot index.
    always_comb begin
        w_slice = '0;
        for (int i = 0; i < MAX_SEGS; i++) begin
            w_slice = w_slice | ({IF_W{r_seg_idx == SEG_CNT_W'(i)}} & w_padded[i*IF_W +: IF_W]);
        end
    end

    // Bytes past the valid count are forced to zero.
    always_comb begin
        w_seg_data = '0;
        for (int b = 0; b < BYTES_PER_SEG; b++) begin
            w_seg_data[b*8 +: 8] = w_keep[b] ? w_slice[b*8 +: 8] : 8'h00;
        end
    end

    assign w_pay_d = {w_seg_data,
                      SEG_BYTES_W'(w_bytes_full),
                      beat_user_i,
                      r_sop_pending && (r_seg_idx == {SEG_CNT_W{1'b0}}),
                      beat_last_i && w_final};

    // Segment index, FSM and packet-start tracking.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= SEG_IDLE;
            r_seg_idx     <= '0;
            r_sop_pending <= 1'b1;
        end else if (flush_i) begin
            r_state       <= SEG_IDLE;
            r_seg_idx     <= '0;
            r_sop_pending <= 1'b1;
        end else if (w_load && w_final) begin
            r_state       <= SEG_IDLE;
            r_seg_idx     <= '0;
            r_sop_pending <= beat_last_i;
        end else if (w_load) begin
            r_state       <= SEG_SEND;
            r_seg_idx     <= r_seg_idx + SEG_CNT_W'(1);
            r_sop_pending <= r_sop_pending;
        end else begin
            r_state       <= r_state;
            r_seg_idx     <= r_seg_idx;
            r_sop_pending <= r_sop_pending;
        end
    end

    axi_bridge_ip_tx_ser_seg_outreg #(
        .PAY_W (PAY_W)
    ) u_outreg (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .flush_i   (flush_i),
        .load_i    (w_load),
        .ready_i   (seg_ready_i),
        .payload_i (w_pay_d),
        .valid_o   (w_seg_valid),
        .payload_o (w_pay_q)
    );

    assign seg_valid_o = w_seg_valid;
    assign {seg_data_o, seg_bytes_o, seg_user_o, seg_sop_o, seg_eop_o} = w_pay_q;

endmodule

// File: tb/tb_axi_bridge_ip_tx_ser_segment_gen.sv
// Directed bench for the TX serializer segment generator.
module tb_axi_bridge_ip_tx_ser_segment_gen;

    localparam int DATA_W  = 256;
    localparam int IF_W    = 64;
    localparam int TUSER_W = 16;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         enable_i;
    logic         flush_i;
    logic         beat_valid_i;
    logic [255:0] beat_data_i;
    logic [15:0]  beat_user_i;
    logic         beat_last_i;
    logic [2:0]   beat_num_segs_i;
    logic [5:0]   beat_last_seg_bytes_i;
    logic         beat_done_pulse_o;
    logic         seg_valid_o;
    logic         seg_ready_i;
    logic [63:0]  seg_data_o;
    logic [3:0]   seg_bytes_o;
    logic [15:0]  seg_user_o;
    logic         seg_sop_o;
    logic         seg_eop_o;

    int checks   = 0;
    int failures = 0;

    logic [255:0] d0, d1, d2;
    logic [86:0]  obs;
    logic [86:0]  expv;

    always #5 clk_i = ~clk_i;

    assign obs = {seg_valid_o, seg_bytes_o, seg_sop_o, seg_eop_o, seg_user_o, seg_data_o};

    axi_bridge_ip_tx_ser_segment_gen #(
        .DATA_W  (DATA_W),
        .IF_W    (IF_W),
        .TUSER_W (TUSER_W)
    ) dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .enable_i              (enable_i),
        .flush_i               (flush_i),
        .beat_valid_i          (beat_valid_i),
        .beat_data_i           (beat_data_i),
        .beat_user_i           (beat_user_i),
        .beat_last_i           (beat_last_i),
        .beat_num_segs_i       (beat_num_segs_i),
        .beat_last_seg_bytes_i (beat_last_seg_bytes_i),
        .beat_done_pulse_o     (beat_done_pulse_o),
        .seg_valid_o           (seg_valid_o),
        .seg_ready_i           (seg_ready_i),
        .seg_data_o            (seg_data_o),
        .seg_bytes_o           (seg_bytes_o),
        .seg_user_o            (seg_user_o),
        .seg_sop_o             (seg_sop_o),
        .seg_eop_o             (seg_eop_o)
    );

    // Reference segment: slot idx of the beat, bytes at or above nb zeroed.
    function automatic logic [86:0] exp_vec(input logic [255:0] d, input int idx, input int nb,
                                            input logic sop, input logic eop, input logic [15:0] u);
        logic [63:0] r;
        r = d[idx*64 +: 64];
        for (int b = nb; b < 8; b++) r[b*8 +: 8] = 8'h00;
        return {1'b1, 4'(nb), sop, eop, u, r};
    endfunction

    task automatic test_reset();
        rst_ni = 1'b0; enable_i = 1'b0; flush_i = 1'b0; beat_valid_i = 1'b0;
        beat_data_i = '0; beat_user_i = 16'h0000; beat_last_i = 1'b0;
        beat_num_segs_i = 3'd0; beat_last_seg_bytes_i = 6'd0; seg_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if (obs !== 87'd0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", obs); end
        checks++;
        if (beat_done_pulse_o !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", beat_done_pulse_o); end
        @(posedge clk_i); #1 rst_ni = 1'b1; enable_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (obs !== 87'd0) begin failures++; $display("FAIL post_reset_outputs got=%h exp=0", obs); end
    endtask

    task automatic test_full_beat();
        int vld   [6] = '{1, 1, 1, 1, 0, 0};
        int done  [6] = '{0, 0, 0, 1, 0, 0};
        int shown [6] = '{-1, 0, 1, 2, 3, -1};
        beat_data_i = d0; beat_user_i = 16'hA5A5; beat_last_i = 1'b1;
        beat_num_segs_i = 3'd4; beat_last_seg_bytes_i = 6'd8;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk_i); #1 beat_valid_i = (vld[c] != 0);
            @(negedge clk_i);
            checks++;
            if (beat_done_pulse_o !== (done[c] != 0)) begin failures++;
                $display("FAIL full_done c=%0d got=%b exp=%0d", c, beat_done_pulse_o, done[c]); end
            checks++;
            if (shown[c] < 0) begin
                if (seg_valid_o !== 1'b0) begin failures++; $display("FAIL full_idle c=%0d got=%b exp=0", c, seg_valid_o); end
            end else begin
                expv = exp_vec(d0, shown[c], 8, shown[c] == 0, shown[c] == 3, 16'hA5A5);
                if (obs !== expv) begin failures++; $display("FAIL full_seg c=%0d got=%h exp=%h", c, obs, expv); end
            end
        end
    endtask

    task automatic test_partial_beat();
        int vld   [5] = '{1, 1, 1, 0, 0};
        int done  [5] = '{0, 0, 1, 0, 0};
        int shown [5] = '{-1, 0, 1, 2, -1};
        beat_data_i = d1; beat_user_i = 16'h1234; beat_last_i = 1'b1;
        beat_num_segs_i = 3'd3; beat_last_seg_bytes_i = 6'd4;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk_i); #1 beat_valid_i = (vld[c] != 0);
            @(negedge clk_i);
            checks++;
            if (beat_done_pulse_o !== (done[c] != 0)) begin failures++;
                $display("FAIL partial_done c=%0d got=%b exp=%0d", c, beat_done_pulse_o, done[c]); end
            checks++;
            if (shown[c] < 0) begin
                if (seg_valid_o !== 1'b0) begin failures++; $display("FAIL partial_idle c=%0d got=%b exp=0", c, seg_valid_o); end
            end else begin
                expv = exp_vec(d1, shown[c], (shown[c] == 2) ? 4 : 8, shown[c] == 0, shown[c] == 2, 16'h1234);
                if (obs !== expv) begin failures++; $display("FAIL partial_seg c=%0d got=%h exp=%h", c, obs, expv); end
            end
            if (shown[c] == 2) begin
                checks++;
                if (seg_data_o[63:32] !== 32'h0) begin failures++;
                    $display("FAIL partial_upper_zero got=%h exp=0", seg_data_o[63:32]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int k;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk_i); #1;
            beat_valid_i = (c < 8);
            beat_data_i  = (c < 4) ? d0 : d2;
            beat_user_i  = (c < 4) ? 16'h0A0A : 16'h0B0B;
            beat_last_i  = (c >= 4);
            beat_num_segs_i = 3'd4; beat_last_seg_bytes_i = 6'd8;
            @(negedge clk_i);
            checks++;
            if (beat_done_pulse_o !== (c == 3 || c == 7)) begin failures++;
                $display("FAIL b2b_done c=%0d got=%b", c, beat_done_pulse_o); end
            checks++;
            if (c == 0 || c == 9) begin
                if (seg_valid_o !== 1'b0) begin failures++; $display("FAIL b2b_idle c=%0d got=%b exp=0", c, seg_valid_o); end
            end else begin
                k = c - 1;
                expv = exp_vec((k < 4) ? d0 : d2, k % 4, 8, k == 0, k == 7, (k < 4) ? 16'h0A0A : 16'h0B0B);
                if (obs !== expv) begin failures++; $display("FAIL b2b_seg c=%0d got=%h exp=%h", c, obs, expv); end
            end
        end
    endtask

    task automatic test_backpressure();
        int vld   [9] = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
        int rdy   [9] = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
        int done  [9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
        int shown [9] = '{-1, 0, 1, 1, 1, 1, 2, 3, -1};
        beat_data_i = d0; beat_user_i = 16'hC3C3; beat_last_i = 1'b1;
        beat_num_segs_i = 3'd4; beat_last_seg_bytes_i = 6'd8;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk_i); #1 beat_valid_i = (vld[c] != 0); seg_ready_i = (rdy[c] != 0);
            @(negedge clk_i);
            checks++;
            if (beat_done_pulse_o !== (done[c] != 0)) begin failures++;
                $display("FAIL bp_done c=%0d got=%b exp=%0d", c, beat_done_pulse_o, done[c]); end
            checks++;
            if (shown[c] < 0) begin
                if (seg_valid_o !== 1'b0) begin failures++; $display("FAIL bp_idle c=%0d got=%b exp=0", c, seg_valid_o); end
            end else begin
                expv = exp_vec(d0, shown[c], 8, shown[c] == 0, shown[c] == 3, 16'hC3C3);
                if (obs !== expv) begin failures++; $display("FAIL bp_seg c=%0d got=%h exp=%h", c, obs, expv); end
            end
        end
        seg_ready_i = 1'b1;
    endtask

    task automatic test_flush();
        int sel   [8] = '{1, 1, 1, 1, 2, 2, 0, 0};
        int done  [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
        int sbeat [8] = '{0, 1, 1, 1, 0, 2, 2, 0};
        int sseg  [8] = '{0, 0, 1, 2, 0, 0, 1, 0};
        for (int c = 0; c < 8; c++) begin
            @(posedge clk_i); #1;
            flush_i      = (c == 3);
            beat_valid_i = (sel[c] != 0);
            beat_data_i  = (sel[c] == 2) ? d2 : d1;
            beat_user_i  = (sel[c] == 2) ? 16'h2222 : 16'hF1F1;
            beat_last_i  = (sel[c] == 2);
            beat_num_segs_i = (sel[c] == 2) ? 3'd2 : 3'd4;
            beat_last_seg_bytes_i = 6'd8;
            @(negedge clk_i);
            checks++;
            if (beat_done_pulse_o !== (done[c] != 0)) begin failures++;
                $display("FAIL flush_done c=%0d got=%b exp=%0d", c, beat_done_pulse_o, done[c]); end
            checks++;
            if (sbeat[c] == 0) begin
                if (seg_valid_o !== 1'b0) begin failures++; $display("FAIL flush_idle c=%0d got=%b exp=0", c, seg_valid_o); end
            end else begin
                expv = exp_vec((sbeat[c] == 2) ? d2 : d1, sseg[c], 8, sseg[c] == 0,
                               (sbeat[c] == 2) && (sseg[c] == 1), (sbeat[c] == 2) ? 16'h2222 : 16'hF1F1);
                if (obs !== expv) begin failures++; $display("FAIL flush_seg c=%0d got=%h exp=%h", c, obs, expv); end
            end
        end
        flush_i = 1'b0;
    endtask

    task automatic test_zero_and_enable();
        int en    [8] = '{1, 1, 0, 0, 1, 1, 1, 1};
        int vld   [8] = '{1, 0, 1, 1, 1, 1, 0, 0};
        int done  [8] = '{1, 0, 0, 0, 0, 1, 0, 0};
        int shown [8] = '{-1, -1, -1, -1, -1, 0, 1, -1};
        beat_data_i = d0; beat_user_i = 16'h5A5A; beat_last_i = 1'b1; beat_last_seg_bytes_i = 6'd8;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk_i); #1;
            enable_i = (en[c] != 0); beat_valid_i = (vld[c] != 0);
            beat_num_segs_i = (c == 0) ? 3'd0 : 3'd2;
            @(negedge clk_i);
            checks++;
            if (beat_done_pulse_o !== (done[c] != 0)) begin failures++;
                $display("FAIL zero_en_done c=%0d got=%b exp=%0d", c, beat_done_pulse_o, done[c]); end
            checks++;
            if (shown[c] < 0) begin
                if (seg_valid_o !== 1'b0) begin failures++; $display("FAIL zero_en_idle c=%0d got=%b exp=0", c, seg_valid_o); end
            end else begin
                expv = exp_vec(d0, shown[c], 8, shown[c] == 0, shown[c] == 1, 16'h5A5A);
                if (obs !== expv) begin failures++; $display("FAIL zero_en_seg c=%0d got=%h exp=%h", c, obs, expv); end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 32; k++) begin
            d0[k*8 +: 8] = 8'(k + 1);
            d1[k*8 +: 8] = 8'(8'hA0 + k);
            d2[k*8 +: 8] = 8'(k * 7 + 3);
        end
        test_reset();
        test_full_beat();
        test_partial_beat();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_zero_and_enable();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
